risc_toy_fetch: RTL

Instruction-fetch stage for the RISC_TOY core. It sits directly upstream of the decode stage. It owns the program counter and drives the instruction-memory request port (IREQ/IADDR/INSTR). It buffers returned instruction words, each tagged with its PC, in a small FIFO and hands them to decode over a valid/ready handshake. A redirect input from the branch/jump resolution logic flushes the buffer, discards any in-flight fetch, and restarts fetch at the target.

---
 rtl/risc_toy_fetch.sv | 99 +++++++++
 1 files changed

// File: rtl/risc_toy_fetch.sv
// RISC_TOY instruction-fetch stage: owns the PC, issues IMEM requests and
// buffers {instr, pc} pairs for decode; redirects flush and restart fetch.
module risc_toy_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IREQ,
    output logic [29:0] IADDR,
    input  logic [31:0] INSTR,
    input  logic        REDIR_VALID,
    input  logic [31:0] REDIR_PC,
    output logic        ID_VALID,
    input  logic        ID_READY,
    output logic [31:0] ID_INSTR,
    output logic [31:0] ID_PC
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;

    logic [31:0]   buf_instr [DEPTH];
    logic [31:0]   buf_pc    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [CW:0]   occupancy;
    logic          push;
    logic          pop;
    logic          unused_redir_lsbs;

    assign unused_redir_lsbs = ^REDIR_PC[1:0];

    // The in-flight word already owns a slot, so it counts against space.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};

    assign IREQ  = !RST && !REDIR_VALID && (occupancy < DEPTH_W);
    assign IADDR = fetch_pc[31:2];

    assign ID_VALID = (count != '0);
    assign ID_INSTR = ID_VALID ? buf_instr[rd_ptr] : 32'h0;
    assign ID_PC    = ID_VALID ? buf_pc[rd_ptr] : 32'h0;

    assign push = inflight && !REDIR_VALID && !RST;
    assign pop  = ID_VALID && ID_READY && !REDIR_VALID && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc    <= {RESET_PC[31:2], 2'b00};
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
        end else if (REDIR_VALID) begin
            fetch_pc    <= {REDIR_PC[31:2], 2'b00};
            inflight    <= 1'b0;
        end else if (IREQ) begin
            fetch_pc    <= fetch_pc + 32'd4;
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
        end else begin
            inflight    <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || REDIR_VALID) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge CLK) begin
        if (push) begin
            buf_instr[wr_ptr] <= INSTR;
            buf_pc[wr_ptr]    <= inflight_pc;
        end
    end

endmodule
